// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of one sram_controller slave port, with read-tag FIFO.
// Optional periodic refresh scheduler enabled by defining SDRAM_ARB_REFRESH_EN.
module sdram_port_arbiter #(
    parameter int unsigned RD_FIFO_DEPTH  = 4,
    parameter int unsigned REFRESH_CYCLES = 1560
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_cs,
    input  logic        m0_rd_n,
    input  logic        m0_wr_n,
    input  logic [3:0]  m0_be_n,
    input  logic [21:0] m0_addr,
    input  logic [31:0] m0_data,
    output logic        m0_waitrequest,
    output logic        m0_valid,
    output logic [31:0] m0_rdata,
    input  logic        m1_cs,
    input  logic        m1_rd_n,
    input  logic        m1_wr_n,
    input  logic [3:0]  m1_be_n,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m1_data,
    output logic        m1_waitrequest,
    output logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        az_cs,
    output logic        az_rd_n,
    output logic        az_wr_n,
    output logic [3:0]  az_be_n,
    output logic [21:0] az_addr,
    output logic [31:0] az_data,
    input  logic        za_waitrequest,
    input  logic        za_valid,
    input  logic [31:0] za_data,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        err_orphan
);
    localparam int unsigned PW = $clog2(RD_FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(RD_FIFO_DEPTH);

`ifdef SDRAM_ARB_REFRESH_EN
    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StRefresh} state_t;
`else
    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_t;
`endif

    state_t                   state_q;
    logic                     rr_q;
    logic [RD_FIFO_DEPTH-1:0] tags_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [PW:0]              count_q;
    logic                     ref_pend;

    logic        granted, sel;
    logic        g_cs, g_rd_n, g_wr_n;
    logic [3:0]  g_be_n;
    logic [21:0] g_addr;
    logic [31:0] g_data;
    logic        rd_blocked, accept, push, pop, pop_tag;

    assign granted = (state_q == StGnt0) || (state_q == StGnt1);
    assign sel     = (state_q == StGnt1);
    assign g_cs    = sel ? m1_cs   : m0_cs;
    assign g_rd_n  = sel ? m1_rd_n : m0_rd_n;
    assign g_wr_n  = sel ? m1_wr_n : m0_wr_n;
    assign g_be_n  = sel ? m1_be_n : m0_be_n;
    assign g_addr  = sel ? m1_addr : m0_addr;
    assign g_data  = sel ? m1_data : m0_data;

    // Full check uses the registered count, so a same-cycle pop cannot unblock a read.
    assign rd_blocked = granted & ~g_rd_n & (count_q == FULL);
    assign accept     = granted & g_cs & ~za_waitrequest & ~rd_blocked;
    assign push       = accept & ~g_rd_n;
    assign pop        = za_valid & (count_q != '0);
    assign pop_tag    = tags_q[rd_ptr_q];

    always_comb begin
        az_cs          = granted & g_cs & ~rd_blocked;
        az_rd_n        = granted ? g_rd_n : 1'b1;
        az_wr_n        = granted ? g_wr_n : 1'b1;
        az_be_n        = granted ? g_be_n : 4'hF;
        az_addr        = granted ? g_addr : '0;
        az_data        = granted ? g_data : '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state_q == StGnt0) m0_waitrequest = za_waitrequest | rd_blocked;
        if (state_q == StGnt1) m1_waitrequest = za_waitrequest | rd_blocked;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            tags_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m0_valid   <= 1'b0;
            m1_valid   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            err_orphan <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef SDRAM_ARB_REFRESH_EN
                    if (ref_pend && count_q == '0) state_q <= StRefresh;
                    else
`endif
                    if (!ref_pend) begin
                        if (m0_cs && m1_cs) state_q <= rr_q ? StGnt1 : StGnt0;
                        else if (m0_cs)     state_q <= StGnt0;
                        else if (m1_cs)     state_q <= StGnt1;
                    end
                end
                StGnt0, StGnt1: begin
                    if (!g_cs || accept) state_q <= StIdle;
                    if (accept) rr_q <= ~sel;
                end
`ifdef SDRAM_ARB_REFRESH_EN
                StRefresh: if (ref_ack) state_q <= StIdle;
`endif
                default: state_q <= StIdle;
            endcase

            if (push) begin
                tags_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;

            m0_valid <= pop & ~pop_tag;
            m1_valid <= pop & pop_tag;
            if (pop && !pop_tag) m0_rdata <= za_data;
            if (pop && pop_tag)  m1_rdata <= za_data;
            if (za_valid && count_q == '0) err_orphan <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int unsigned CW = $clog2(REFRESH_CYCLES + 1);
    logic [CW-1:0] ref_cnt_q;
    logic          ref_pend_q;

    // A counter expiry in the same cycle as ref_ack wins, so no refresh is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_q  <= CW'(REFRESH_CYCLES);
            ref_pend_q <= 1'b0;
        end else begin
            if (state_q == StRefresh && ref_ack) ref_pend_q <= 1'b0;
            if (ref_cnt_q == '0) begin
                ref_pend_q <= 1'b1;
                ref_cnt_q  <= CW'(REFRESH_CYCLES);
            end else begin
                ref_cnt_q <= ref_cnt_q - 1'b1;
            end
        end
    end

    assign ref_pend = ref_pend_q;
    assign ref_req  = (state_q == StRefresh);
`else
    logic unused_ref;
    assign ref_pend   = 1'b0;
    assign ref_req    = 1'b0;
    assign unused_ref = ref_ack | (REFRESH_CYCLES == 0);
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios then random traffic,
// every cycle compared against a queue-based transaction model.
module tb_sdram_port_arbiter;
`ifdef SDRAM_ARB_REFRESH_EN
    localparam int unsigned RC = 20;
`else
    localparam int unsigned RC = 1560;
`endif
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cs, rd_n, wr_n;
    logic [3:0]  be_n [2];
    logic [21:0] addr [2];
    logic [31:0] data [2];
    logic        za_waitrequest, za_valid, ref_ack;
    logic [31:0] za_data;
    logic        m0_waitrequest, m0_valid, m1_waitrequest, m1_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        az_cs, az_rd_n, az_wr_n, ref_req, err_orphan;
    logic [3:0]  az_be_n;
    logic [21:0] az_addr;
    logic [31:0] az_data;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.RD_FIFO_DEPTH(DEPTH), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .reset(reset),
        .m0_cs(cs[0]), .m0_rd_n(rd_n[0]), .m0_wr_n(wr_n[0]), .m0_be_n(be_n[0]),
        .m0_addr(addr[0]), .m0_data(data[0]), .m0_waitrequest(m0_waitrequest),
        .m0_valid(m0_valid), .m0_rdata(m0_rdata),
        .m1_cs(cs[1]), .m1_rd_n(rd_n[1]), .m1_wr_n(wr_n[1]), .m1_be_n(be_n[1]),
        .m1_addr(addr[1]), .m1_data(data[1]), .m1_waitrequest(m1_waitrequest),
        .m1_valid(m1_valid), .m1_rdata(m1_rdata),
        .az_cs(az_cs), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .az_be_n(az_be_n),
        .az_addr(az_addr), .az_data(az_data),
        .za_waitrequest(za_waitrequest), .za_valid(za_valid), .za_data(za_data),
        .ref_req(ref_req), .ref_ack(ref_ack), .err_orphan(err_orphan)
    );

    // Model: owner -1 = nobody granted, 0/1 = master granted, 2 = refresh window.
    int          owner;
    bit          rr;
    bit          tags [$];
    bit          ev [2];
    logic [31:0] erd [2];
    bit          eorph, pend, model_ok;
    int          rcnt;
    int          n_checks, n_fail;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        ecs, erdn, ewrn;
        logic [3:0]  ebe;
        logic [21:0] ea;
        logic [31:0] ed;
        logic [1:0]  ew;
        ecs = 1'b0; erdn = 1'b1; ewrn = 1'b1; ebe = 4'hF; ea = '0; ed = '0; ew = 2'b11;
        if (owner == 0 || owner == 1) begin
            bit blk;
            blk  = !rd_n[owner] && tags.size() == DEPTH;
            ecs  = cs[owner] && !blk;
            erdn = rd_n[owner]; ewrn = wr_n[owner]; ebe = be_n[owner];
            ea   = addr[owner]; ed = data[owner];
            ew[owner] = za_waitrequest || blk;
        end
        chk1("az_cs", az_cs, ecs);
        chk1("az_rd_n", az_rd_n, erdn);
        chk1("az_wr_n", az_wr_n, ewrn);
        chk("az_be_n", 32'(az_be_n), 32'(ebe));
        chk("az_addr", 32'(az_addr), 32'(ea));
        chk("az_data", az_data, ed);
        chk1("m0_waitrequest", m0_waitrequest, ew[0]);
        chk1("m1_waitrequest", m1_waitrequest, ew[1]);
        chk1("m0_valid", m0_valid, ev[0]);
        chk1("m1_valid", m1_valid, ev[1]);
        if (ev[0]) chk("m0_rdata", m0_rdata, erd[0]);
        if (ev[1]) chk("m1_rdata", m1_rdata, erd[1]);
        chk1("err_orphan", err_orphan, eorph);
        chk1("ref_req", ref_req, owner == 2);
    endtask

    task automatic model_step();
        int sz;
        bit old_pend, clr;
        if (reset) begin
            owner = -1; rr = 0; tags.delete(); ev[0] = 0; ev[1] = 0;
            erd[0] = '0; erd[1] = '0; eorph = 0; pend = 0; rcnt = RC; model_ok = 1;
            return;
        end
        sz = tags.size(); old_pend = pend; clr = 0;
        ev[0] = 0; ev[1] = 0;
        if (za_valid) begin
            if (sz > 0) begin
                bit t;
                t = tags.pop_front();
                ev[t] = 1; erd[t] = za_data;
            end else eorph = 1;
        end
        if (owner == -1) begin
            if (old_pend && sz == 0) owner = 2;
            else if (!old_pend) begin
                if (cs == 2'b11) owner = int'(rr);
                else if (cs[0]) owner = 0;
                else if (cs[1]) owner = 1;
            end
        end else if (owner == 2) begin
            if (ref_ack) begin owner = -1; clr = 1; end
        end else begin
            int n;
            n = owner;
            if (!cs[n]) owner = -1;
            else if (!za_waitrequest && !(!rd_n[n] && sz == DEPTH)) begin
                if (!rd_n[n]) tags.push_back(n[0]);
                rr = (n == 0);
                owner = -1;
            end
        end
`ifdef SDRAM_ARB_REFRESH_EN
        if (clr) pend = 0;
        if (rcnt == 0) begin pend = 1; rcnt = RC; end
        else rcnt--;
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_ok) check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet();
        cs = 2'b00; rd_n = 2'b11; wr_n = 2'b11;
        for (int i = 0; i < 2; i++) begin be_n[i] = 4'hF; addr[i] = '0; data[i] = '0; end
        za_waitrequest = 0; za_valid = 0; za_data = '0; ref_ack = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; model_ok = 0;
        quiet();
        do_reset();
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_az_rd_n", az_rd_n, 1'b1);
        chk("rst_az_be_n", 32'(az_be_n), 32'hF);

        // Single write from M0: grant one cycle after cs, az_* follows M0.
        cs[0] = 1; wr_n[0] = 0; be_n[0] = 4'h0; addr[0] = 22'h000010; data[0] = 32'hDEADBEEF;
        tick();
        chk("t1_az_addr", 32'(az_addr), 32'h10);
        chk("t1_az_data", az_data, 32'hDEADBEEF);
        chk1("t1_m0_wait", m0_waitrequest, 1'b0);
        tick();
        quiet();
        ticks(2);
        chk1("t1_no_push", m0_valid, 1'b0);

        // Contention: both masters read continuously; grants alternate.
        cs = 2'b11; rd_n = 2'b00; addr[0] = 22'h100; addr[1] = 22'h200;
        ticks(8);
        quiet();
        za_valid = 1;
        for (int i = 1; i <= 4; i++) begin za_data = 32'(i); tick(); end
        za_valid = 0;
        ticks(2);

        // FIFO full: the fifth M1 read stalls until a pop, and issues the cycle after.
        cs[1] = 1; rd_n[1] = 0; addr[1] = 22'h3FF;
        ticks(10);
        chk1("t3_az_cs_blocked", az_cs, 1'b0);
        chk1("t3_m1_wait", m1_waitrequest, 1'b1);
        za_valid = 1; za_data = 32'hA5A5_0001;
        tick();
        za_valid = 0;
        chk1("t3_az_cs_issue", az_cs, 1'b1);
        tick();
        quiet();
        za_valid = 1;
        for (int i = 0; i < 4; i++) begin za_data = 32'hB000_0000 + 32'(i); tick(); end
        za_valid = 0;
        ticks(2);

        // Orphan return with nothing outstanding.
        za_valid = 1; za_data = 32'hBAD0_BAD0;
        tick();
        za_valid = 0;
        ticks(3);
        chk1("t4_orphan_sticky", err_orphan, 1'b1);
        chk1("t4_m0_valid", m0_valid, 1'b0);

`ifdef SDRAM_ARB_REFRESH_EN
        // Refresh window preempts continuous M0 writes.
        do_reset();
        cs[0] = 1; wr_n[0] = 0; addr[0] = 22'h55; data[0] = 32'h1234_5678;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                tick();
                seen = ref_req;
            end
            chk1("t5_ref_req_seen", seen, 1'b1);
        end
        ticks(3);
        ref_ack = 1; tick(); ref_ack = 0;
        ticks(10);
        quiet();
`endif

        // Reset while M1 is granted with two reads outstanding.
        do_reset();
        cs[1] = 1; rd_n[1] = 0; addr[1] = 22'h77;
        ticks(5);
        reset = 1; tick(); reset = 0;
        quiet();
        chk1("t6_m0_wait", m0_waitrequest, 1'b1);
        chk1("t6_m1_wait", m1_waitrequest, 1'b1);
        za_valid = 1; za_data = 32'hCAFE_F00D;
        tick();
        za_valid = 0;
        tick();
        chk1("t6_late_orphan", err_orphan, 1'b1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cs   = 2'($urandom_range(0, 3));
            rd_n = 2'($urandom_range(0, 3));
            wr_n = ~rd_n;
            for (int m = 0; m < 2; m++) begin
                be_n[m] = 4'($urandom); addr[m] = 22'($urandom); data[m] = $urandom;
            end
            za_waitrequest = ($urandom_range(0, 3) == 0);
            za_valid       = ($urandom_range(0, 3) == 0);
            za_data        = $urandom;
            ref_ack        = ($urandom_range(0, 3) == 0);
            tick();
        end
        quiet();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
